// File: rtl/mux_arb_2a1.sv
// Two-requester round-robin arbiter for a shared 2:1 mux: grants ownership with
// break-before-make turnaround and a bounded hold time, and registers the muxed word.
module mux_arb_2a1 #(
  parameter int W       = 8,
  parameter int MAXHOLD = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic [1:0]   gnt,
  output logic         s,
  output logic [W-1:0] y,
  output logic         v,
  output logic         to
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter value on the last permitted cycle of a grant; unused when the limit is off.
  localparam logic [7:0] HOLD_LAST = (MAXHOLD == 0) ? 8'd0 : 8'(MAXHOLD - 1);
  localparam bit         HOLD_ON   = (MAXHOLD != 0);

  state_t       state, state_d;
  logic         owner, owner_d;
  logic         ptr, ptr_d;
  logic [7:0]   cnt, cnt_d;
  logic [1:0]   gnt_d;
  logic         s_d;
  logic         v_d;
  logic         to_d;
  logic [W-1:0] y_d;

  logic owner_req;
  logic hold_expired;
  logic winner;

  assign owner_req    = req[owner];
  assign hold_expired = HOLD_ON && (cnt == HOLD_LAST);
  // A lone requester wins outright; a tie goes to the priority pointer.
  assign winner       = (req == 2'b11) ? ptr : req[1];

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    owner_d = owner;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gnt_d   = gnt;
    s_d     = s;
    to_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = BUSY;
          owner_d = winner;
          gnt_d   = winner ? 2'b10 : 2'b01;
          s_d     = winner;
          cnt_d   = 8'd0;
        end
      end

      BUSY: begin
        // A release takes precedence over a coincident timeout.
        if (!owner_req) begin
          state_d = GAP;
          gnt_d   = 2'b00;
          ptr_d   = ~owner;
        end else if (hold_expired) begin
          state_d = GAP;
          gnt_d   = 2'b00;
          ptr_d   = ~owner;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      GAP: begin
        // Select never moves while a grant is live; this cycle is the turnaround.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    v_d = (state == BUSY) && owner_req;
    y_d = v_d ? (owner ? x1 : x0) : y;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= 1'b0;
      cnt   <= 8'd0;
      gnt   <= 2'b00;
      s     <= 1'b0;
      y     <= '0;
      v     <= 1'b0;
      to    <= 1'b0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      gnt   <= gnt_d;
      s     <= s_d;
      y     <= y_d;
      v     <= v_d;
      to    <= to_d;
    end
  end

endmodule

// File: tb/tb_mux_arb_2a1.sv
// Directed bench for mux_arb_2a1: one instance with the default hold limit and
// one with MAXHOLD = 3, driven from shared inputs.
module tb_mux_arb_2a1;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] x0, x1;

  logic [1:0] gnt_a, gnt_b;
  logic       s_a, s_b, v_a, v_b, to_a, to_b;
  logic [7:0] y_a, y_b;

  int n_cmp = 0;
  int n_err = 0;

  mux_arb_2a1 #(.W(8), .MAXHOLD(15)) dut (
    .clk(clk), .rst(rst), .req(req), .x0(x0), .x1(x1),
    .gnt(gnt_a), .s(s_a), .y(y_a), .v(v_a), .to(to_a)
  );

  mux_arb_2a1 #(.W(8), .MAXHOLD(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .x0(x0), .x1(x1),
    .gnt(gnt_b), .s(s_b), .y(y_b), .v(v_b), .to(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic [1:0] g, input logic sel,
                       input logic vv, input logic [7:0] yy, input logic tt);
    chk({tag, ".a.gnt"}, 32'(gnt_a), 32'(g));
    chk({tag, ".a.s"},   32'(s_a),   32'(sel));
    chk({tag, ".a.v"},   32'(v_a),   32'(vv));
    chk({tag, ".a.y"},   32'(y_a),   32'(yy));
    chk({tag, ".a.to"},  32'(to_a),  32'(tt));
  endtask

  task automatic exp_b(input string tag, input logic [1:0] g, input logic sel,
                       input logic vv, input logic [7:0] yy, input logic tt);
    chk({tag, ".b.gnt"}, 32'(gnt_b), 32'(g));
    chk({tag, ".b.s"},   32'(s_b),   32'(sel));
    chk({tag, ".b.v"},   32'(v_b),   32'(vv));
    chk({tag, ".b.y"},   32'(y_b),   32'(yy));
    chk({tag, ".b.to"},  32'(to_b),  32'(tt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // MAXHOLD = 3 with both sources requesting forever: 3 cycles of grant, 2 of gap.
  logic [1:0] g_tab  [11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
  logic       s_tab  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       v_tab  [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] y_tab  [11] = '{8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C,
                              8'h3C, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
  logic       to_tab [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    req = 2'b00;
    x0  = 8'h3C;
    x1  = 8'hA5;
    do_reset();

    // Idle after reset.
    exp_a("reset", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    exp_b("reset", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_a($sformatf("idle%0d", i), 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Single requester on source 1.
    req = 2'b10;
    tick();
    exp_a("single.grant", 2'b10, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_a($sformatf("single.data%0d", i), 2'b10, 1'b1, 1'b1, 8'hA5, 1'b0);
    end
    req = 2'b00;
    tick();
    exp_a("single.release", 2'b00, 1'b1, 1'b0, 8'hA5, 1'b0);
    tick();
    exp_a("single.gap", 2'b00, 1'b1, 1'b0, 8'hA5, 1'b0);

    // Simultaneous requests from reset: 0 first, then 1, then 0 again.
    do_reset();
    req = 2'b11;
    tick();
    exp_a("rr.g0", 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    exp_a("rr.d0a", 2'b01, 1'b0, 1'b1, 8'h3C, 1'b0);
    tick();
    exp_a("rr.d0b", 2'b01, 1'b0, 1'b1, 8'h3C, 1'b0);
    // Source 0 drops exactly when the MAXHOLD=3 copy would time out: release wins.
    req = 2'b10;
    tick();
    exp_a("rr.rel0", 2'b00, 1'b0, 1'b0, 8'h3C, 1'b0);
    exp_b("relto", 2'b00, 1'b0, 1'b0, 8'h3C, 1'b0);
    tick();
    exp_a("rr.gap0", 2'b00, 1'b0, 1'b0, 8'h3C, 1'b0);
    tick();
    exp_a("rr.g1", 2'b10, 1'b1, 1'b0, 8'h3C, 1'b0);
    req = 2'b00;
    tick();
    exp_a("rr.rel1", 2'b00, 1'b1, 1'b0, 8'h3C, 1'b0);
    tick();
    req = 2'b11;
    tick();
    exp_a("rr.g0again", 2'b01, 1'b0, 1'b0, 8'h3C, 1'b0);
    exp_b("rr.g0again", 2'b01, 1'b0, 1'b0, 8'h3C, 1'b0);

    // Hold-limit alternation on the MAXHOLD=3 copy; default copy keeps source 0.
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 11; i++) begin
      tick();
      exp_b($sformatf("hold.t%0d", i + 1), g_tab[i], s_tab[i], v_tab[i], y_tab[i], to_tab[i]);
      chk($sformatf("hold.a.gnt.t%0d", i + 1), 32'(gnt_a), 32'(2'b01));
    end
    chk("hold.a.v", 32'(v_a), 32'(1'b1));

    // Reset mid-grant with v high, then a tie goes to source 0.
    rst = 1'b1;
    tick();
    exp_a("midrst", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    exp_b("midrst", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    tick();
    exp_a("postrst", 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    exp_b("postrst", 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_2a1.md
# mux_arb_2a1

Two-requester round-robin arbiter and sequencer for the shared 2:1 multiplexer datapath. It decides which of two sources owns the mux, drives the select line, and registers the selected data with a valid flag. It enforces break-before-make turnaround and a bounded hold time, so neither source can starve the other. It sits between the requesting sources and any downstream consumer of the muxed word.

## Interface

- W, 8, data width of each source and of the output
- MAXHOLD, 15, max consecutive cycles a grant may be held; 0 disables the limit; legal range 0..255

- clk  input  1  single clock; all logic is on its rising edge
- rst  input  1  synchronous, active-high reset
- req  input  2  req[i] high while source i wants, or is using, the mux
- x0  input  W  data from source 0
- x1  input  W  data from source 1
- gnt  output  2  one-hot grant, or 00 when no source owns the mux; registered
- s  output  1  mux select (0 selects x0, 1 selects x1); registered; holds its last value while idle
- y  output  W  registered muxed data
- v  output  1  y is valid this cycle
- to  output  1  one-cycle pulse when a grant is force-released by MAXHOLD

## Operation

- State register takes values IDLE, BUSY, GAP. An owner bit and a priority pointer `ptr` (1 bit) complete the control state. `cnt` is an 8-bit hold counter.
- Reset values: state = IDLE, gnt = 00, s = 0, y = 0, v = 0, to = 0, ptr = 0, cnt = 0.
- IDLE:
  - req = 00: stay in IDLE.
  - Exactly one req bit high: grant that source.
  - Both high: grant source `ptr`.
  - On a grant: the next state is BUSY, gnt[owner] = 1, s = owner, cnt = 0.
- BUSY:
  - Each cycle with req[owner] = 1 and no timeout: cnt increments, gnt and s hold.
  - Release when req[owner] = 0: gnt = 00, ptr = ~owner, go to GAP.
  - Timeout when MAXHOLD != 0, req[owner] = 1 and cnt == MAXHOLD-1: gnt = 00, ptr = ~owner, to = 1 for one cycle, go to GAP.
- GAP:
  - Lasts exactly one cycle with gnt = 00, then goes to IDLE.
  - Guarantees the select line never switches while a grant is active.
- Data path:
  - Every cycle, v <= (state == BUSY) && req[owner].
  - When that condition holds, y <= (owner ? x1 : x0). Otherwise y holds.
- A preempted requester that keeps req high is re-granted after GAP and IDLE if the other source is not requesting.
- Simultaneous events:
  - A release and a timeout in the same cycle count as a release; `to` stays 0.
  - A new req from the non-owner during BUSY has no effect until the owner releases.
- Reset asserted mid-grant forces all reset values at the next edge, regardless of state.

## Timing

- Grant latency:
  - req sampled high in IDLE at edge k gives gnt/s valid after edge k.
  - First v/y after edge k+1.
- Release:
  - Owner drops req before edge m: gnt = 00 and v = 0 after edge m.
  - An earliest regrant becomes visible after edge m+2 (GAP, then the IDLE decision).
- Maximum continuous ownership is MAXHOLD cycles of gnt high. The minimum gap between grants is 2 cycles with gnt = 00.
- y/v lag the corresponding gnt cycle by exactly one clock.
- Worst-case wait for a requester with the other source active: MAXHOLD + 2 cycles.

## Test plan

- Reset, then req = 00 for 5 cycles: gnt = 00, s = 0, v = 0, y = 0, to = 0 throughout.
- req = 10, x1 = 8'hA5, held 4 cycles, then dropped:
  - gnt = 10 and s = 1 one cycle after the request.
  - v = 1 with y = A5 for 4 cycles.
  - gnt = 00 two cycles later.
- req = 11 from reset:
  - Source 0 is granted first.
  - After source 0 drops req, source 1 is granted after 2 idle cycles.
  - The next simultaneous request is granted to source 0 again (alternation).
- MAXHOLD = 3, req = 11 held constantly:
  - Grants alternate 01, 10, 01.
  - Each grant is high for 3 cycles, separated by 2 cycles of 00.
  - `to` pulses once per grant.
- Release and timeout in the same cycle (req[owner] drops at cnt == MAXHOLD-1): the block goes to GAP with to = 0.
- rst asserted during BUSY with v = 1: all outputs return to their reset values on the next edge. After rst drops, the grant goes to source 0 when both sources request.
